// File: rtl/zone_min_filter_if.sv
// Bus bundle for zone_min_filter: zone RAM write port, pass control and the
// filtered-zone output stream. master = host side, slave = filter side.
interface zone_min_filter_if #(
  parameter int unsigned DW   = 16,
  parameter int unsigned COLS = 24,
  parameter int unsigned ROWS = 15
);
  localparam int unsigned IW = $clog2(COLS * ROWS);

  logic          gray_we;
  logic [IW-1:0] gray_addr;
  logic [DW-1:0] gray;
  logic          start;
  logic [1:0]    mode;
  logic [DW-1:0] light;
  logic [IW-1:0] light_index;
  logic          light_valid;
  logic          light_ready;
  logic          busy;
  logic          done;

  modport master (
    output gray_we, gray_addr, gray, start, mode, light_ready,
    input  light, light_index, light_valid, busy, done
  );

  modport slave (
    input  gray_we, gray_addr, gray, start, mode, light_ready,
    output light, light_index, light_valid, busy, done
  );
endinterface

// File: rtl/zone_min_filter.sv
// Zone min/max blend filter. Zone values live in an internal RAM; one pass walks
// zones 0..Z-1, reads center plus in-grid neighbours and emits
// floor((center + extreme) / 2) on a valid/ready stream (or center in bypass).
// Optional macro ZONE_FILTER_DIAG_EN adds the four diagonal neighbours (N=9).
module zone_min_filter #(
  parameter int unsigned DW   = 16,
  parameter int unsigned COLS = 24,
  parameter int unsigned ROWS = 15
) (
  input logic              sys_clk,
  input logic              sys_rst,
  zone_min_filter_if.slave bus
);
  localparam int unsigned Z  = COLS * ROWS;
  localparam int unsigned IW = $clog2(Z);
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef ZONE_FILTER_DIAG_EN
  localparam int unsigned N  = 9;
`else
  localparam int unsigned N  = 5;
`endif

  typedef enum logic [2:0] {StIdle, StFetch, StLast, StOut, StDone} state_e;

  state_e state_q, state_d;

  logic [DW-1:0] mem [Z];
  logic [DW-1:0] rdata_q;
  logic [IW-1:0] rd_addr;
  logic          rd_vld;

  logic [IW-1:0] zone_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [3:0]    k_q;
  logic [1:0]    mode_q;
  logic [DW-1:0] center_q, ext_q, light_q;
  logic          pend_first_q, pend_vld_q;

  logic          busy, done, light_valid, hs, last_zone;
  logic          top_ok, bot_ok, lft_ok, rgt_ok;
  logic [DW-1:0] pick, cand, light_d;
  logic [DW:0]   sum;

  assign top_ok    = (row_q != '0);
  assign bot_ok    = (row_q != RW'(ROWS - 1));
  assign lft_ok    = (col_q != '0);
  assign rgt_ok    = (col_q != CW'(COLS - 1));
  assign last_zone = (zone_q == IW'(Z - 1));
  assign hs        = light_valid && bus.light_ready;

  // Zone RAM: no reset; writes only accepted while idle, reads every cycle.
  always_ff @(posedge sys_clk) begin
    if (bus.gray_we && !busy && (32'(bus.gray_addr) < Z)) begin
      mem[bus.gray_addr] <= bus.gray;
    end
    rdata_q <= mem[rd_addr];
  end

  // Neighbour address for fetch step k; absent neighbours read the center harmlessly.
  always_comb begin
    rd_vld  = 1'b1;
    rd_addr = zone_q;
    case (k_q)
      4'd1: begin rd_vld = top_ok; rd_addr = zone_q - IW'(COLS); end
      4'd2: begin rd_vld = lft_ok; rd_addr = zone_q - IW'(1);    end
      4'd3: begin rd_vld = bot_ok; rd_addr = zone_q + IW'(COLS); end
      4'd4: begin rd_vld = rgt_ok; rd_addr = zone_q + IW'(1);    end
`ifdef ZONE_FILTER_DIAG_EN
      4'd5: begin rd_vld = top_ok && lft_ok; rd_addr = zone_q - IW'(COLS + 1); end
      4'd6: begin rd_vld = top_ok && rgt_ok; rd_addr = zone_q - IW'(COLS - 1); end
      4'd7: begin rd_vld = bot_ok && lft_ok; rd_addr = zone_q + IW'(COLS - 1); end
      4'd8: begin rd_vld = bot_ok && rgt_ok; rd_addr = zone_q + IW'(COLS + 1); end
`endif
      default: ;
    endcase
    if (!rd_vld) rd_addr = zone_q;
  end

  // Running extreme: read data lands one cycle after its fetch step.
  always_comb begin
    pick = mode_q[0] ? ((rdata_q > ext_q) ? rdata_q : ext_q)
                     : ((rdata_q < ext_q) ? rdata_q : ext_q);
    cand = ext_q;
    if (pend_first_q)    cand = rdata_q;
    else if (pend_vld_q) cand = pick;
    sum     = {1'b0, center_q} + {1'b0, cand};
    light_d = mode_q[1] ? center_q : DW'(sum >> 1);
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StFetch;
      StFetch: if (k_q == 4'(N - 1)) state_d = StLast;
      StLast:  state_d = StOut;
      StOut:   if (hs) state_d = last_zone ? StDone : StFetch;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy            = (state_q != StIdle);
    done            = (state_q == StDone);
    light_valid     = (state_q == StOut);
    bus.busy        = busy;
    bus.done        = done;
    bus.light_valid = light_valid;
    bus.light       = light_q;
    bus.light_index = zone_q;
  end

  // Counters, compare pipeline and result register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      zone_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      k_q          <= '0;
      mode_q       <= '0;
      center_q     <= '0;
      ext_q        <= '0;
      light_q      <= '0;
      pend_first_q <= 1'b0;
      pend_vld_q   <= 1'b0;
    end else begin
      pend_first_q <= (state_q == StFetch) && (k_q == 4'd0);
      pend_vld_q   <= (state_q == StFetch) && (k_q != 4'd0) && rd_vld;
      if (state_q == StFetch || state_q == StLast) begin
        ext_q <= cand;
        if (pend_first_q) center_q <= rdata_q;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            zone_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            k_q    <= '0;
          end
        end
        StFetch: k_q <= (k_q == 4'(N - 1)) ? 4'd0 : k_q + 4'd1;
        StLast:  light_q <= light_d;
        StOut: begin
          if (hs && !last_zone) begin
            zone_q <= zone_q + IW'(1);
            if (col_q == CW'(COLS - 1)) begin
              col_q <= '0;
              row_q <= row_q + RW'(1);
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_zone_min_filter.sv
// Directed self-checking bench for zone_min_filter (default 24x15 grid, DW=16).
module tb_zone_min_filter;
  localparam int unsigned DW   = 16;
  localparam int unsigned COLS = 24;
  localparam int unsigned ROWS = 15;
  localparam int          Z    = 360;
`ifdef ZONE_FILTER_DIAG_EN
  localparam int          N    = 9;
`else
  localparam int          N    = 5;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  zone_min_filter_if #(.DW(DW), .COLS(COLS), .ROWS(ROWS)) zif ();

  zone_min_filter #(.DW(DW), .COLS(COLS), .ROWS(ROWS)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (zif)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] got     [Z];
  int          acc_cyc [Z];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int addr, input logic [15:0] val);
    zif.gray_we   = 1'b1;
    zif.gray_addr = 9'(addr);
    zif.gray      = val;
    @(negedge sys_clk);
    zif.gray_we   = 1'b0;
  endtask

  task automatic fill(input logic [15:0] val);
    for (int i = 0; i < Z; i++) begin
      zif.gray_we   = 1'b1;
      zif.gray_addr = 9'(i);
      zif.gray      = val;
      @(negedge sys_clk);
    end
    zif.gray_we = 1'b0;
  endtask

  // Start pulse, optionally with a same-cycle RAM write.
  task automatic start_pass(input logic [1:0] m, input bit wr, input int waddr,
                            input logic [15:0] wval);
    zif.start = 1'b1;
    zif.mode  = m;
    if (wr) begin
      zif.gray_we   = 1'b1;
      zif.gray_addr = 9'(waddr);
      zif.gray      = wval;
    end
    @(negedge sys_clk);
    zif.start   = 1'b0;
    zif.gray_we = 1'b0;
    chk("busy_after_start", 32'(zif.busy), 32'd1);
  endtask

  // Accept all zones of a pass; optional stall on one zone and a poke while busy.
  task automatic collect(input int stall_zone, input int stall_len, input bit poke);
    int          n, cyc, stall, dones;
    logic [15:0] held_light;
    logic [8:0]  held_idx;
    logic [1:0]  saved_mode;
    n          = 0;
    cyc        = 0;
    stall      = stall_len;
    dones      = 0;
    held_light = '0;
    held_idx   = '0;
    saved_mode = zif.mode;
    while (n < Z && cyc < 20000) begin
      @(negedge sys_clk);
      cyc++;
      if (poke) begin
        if (cyc == 50) begin zif.start = 1'b1; zif.mode = 2'b10; end
        if (cyc == 51) begin zif.start = 1'b0; zif.mode = saved_mode; end
        if (cyc == 60) begin zif.gray_we = 1'b1; zif.gray_addr = 9'd359; zif.gray = 16'h0; end
        if (cyc == 61) zif.gray_we = 1'b0;
      end
      if (zif.done) dones++;
      if (zif.light_valid) begin
        if (int'(zif.light_index) == stall_zone && stall > 0) begin
          if (stall == stall_len) begin
            held_light = zif.light;
            held_idx   = zif.light_index;
          end else begin
            chk("stall_light_stable", 32'(zif.light), 32'(held_light));
            chk("stall_index_stable", 32'(zif.light_index), 32'(held_idx));
          end
          zif.light_ready = 1'b0;
          stall--;
        end else begin
          zif.light_ready = 1'b1;
          chk($sformatf("index_order_%0d", n), 32'(zif.light_index), 32'(n));
          got[n]     = zif.light;
          acc_cyc[n] = cyc;
          n++;
        end
      end else begin
        zif.light_ready = 1'b1;
      end
    end
    chk("pass_complete", 32'(n), 32'(Z));
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      if (zif.done) dones++;
    end
    zif.light_ready = 1'b1;
    chk("done_once", 32'(dones), 32'd1);
    chk("idle_after_pass", 32'(zif.busy), 32'd0);
    chk("first_latency", 32'(acc_cyc[0]), 32'(N + 1));
    chk("zone_period", 32'(acc_cyc[1] - acc_cyc[0]), 32'(N + 2));
    chk("zone_period_tail", 32'(acc_cyc[Z-1] - acc_cyc[Z-2]), 32'(N + 2));
  endtask

  initial begin
    int          cyc;
    logic [15:0] exp;
    zif.gray_we     = 1'b0;
    zif.gray_addr   = '0;
    zif.gray        = '0;
    zif.start       = 1'b0;
    zif.mode        = 2'b00;
    zif.light_ready = 1'b1;

    // Reset state.
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_light", 32'(zif.light), 32'd0);
    chk("rst_index", 32'(zif.light_index), 32'd0);
    chk("rst_valid", 32'(zif.light_valid), 32'd0);
    chk("rst_busy", 32'(zif.busy), 32'd0);
    chk("rst_done", 32'(zif.done), 32'd0);
    sys_rst = 1'b1;
    @(negedge sys_clk);

    // Min-blend: one dark zone pulls its neighbours to the midpoint.
    fill(16'd100);
    put(25, 16'd20);
    start_pass(2'b00, 1'b0, 0, 16'h0);
    collect(-1, 0, 1'b0);
    for (int z = 0; z < Z; z++) begin
      exp = 16'd100;
      if (z == 25) exp = 16'd20;
      else if (z == 1 || z == 24 || z == 26 || z == 49) exp = 16'd60;
`ifdef ZONE_FILTER_DIAG_EN
      else if (z == 0 || z == 2 || z == 48 || z == 50) exp = 16'd60;
`endif
      chk($sformatf("minblend_zone_%0d", z), 32'(got[z]), 32'(exp));
    end

    // Grid edges: zone 23 (last column) must not see zone 24 (next row start).
    fill(16'd200);
    put(24, 16'd0);
    start_pass(2'b00, 1'b0, 0, 16'h0);
    collect(-1, 0, 1'b0);
    chk("edge_zone23", 32'(got[23]), 32'd200);
    chk("edge_zone24", 32'(got[24]), 32'd0);
    chk("edge_zone0", 32'(got[0]), 32'd100);
    chk("edge_zone25", 32'(got[25]), 32'd100);
    chk("edge_zone48", 32'(got[48]), 32'd100);
    chk("edge_zone47", 32'(got[47]), 32'd200);

    // Max-blend, full-scale sums, stall on zone 5, start and write while busy.
    fill(16'hFFFF);
    put(0, 16'd3);
    put(1, 16'd4);
    put(24, 16'd4);
    put(25, 16'd4);
    start_pass(2'b01, 1'b0, 0, 16'h0);
    collect(5, 10, 1'b1);
    chk("max_zone0", 32'(got[0]), 32'd3);
    chk("max_zone1", 32'(got[1]), 32'h8001);
    chk("max_zone2", 32'(got[2]), 32'hFFFF);
    chk("max_zone5", 32'(got[5]), 32'hFFFF);
    chk("max_zone24", 32'(got[24]), 32'h8001);
    chk("max_zone359", 32'(got[359]), 32'hFFFF);

    // Mode 11 acts as bypass; write in the start cycle is seen by this pass.
    start_pass(2'b11, 1'b1, 2, 16'd7);
    collect(-1, 0, 1'b0);
    chk("byp_zone0", 32'(got[0]), 32'd3);
    chk("byp_zone1", 32'(got[1]), 32'd4);
    chk("byp_zone2", 32'(got[2]), 32'd7);
    chk("byp_zone25", 32'(got[25]), 32'd4);
    chk("byp_zone359_drop", 32'(got[359]), 32'hFFFF);

    // Reset in the middle of a pass, then a clean restart.
    start_pass(2'b00, 1'b0, 0, 16'h0);
    cyc = 0;
    while (!(zif.light_valid && zif.light_index == 9'd100) && cyc < 5000) begin
      @(negedge sys_clk);
      cyc++;
    end
    chk("reach_zone100", 32'(zif.light_index), 32'd100);
    sys_rst = 1'b0;
    #1;
    chk("midrst_light", 32'(zif.light), 32'd0);
    chk("midrst_index", 32'(zif.light_index), 32'd0);
    chk("midrst_valid", 32'(zif.light_valid), 32'd0);
    chk("midrst_busy", 32'(zif.busy), 32'd0);
    chk("midrst_done", 32'(zif.done), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    start_pass(2'b10, 1'b0, 0, 16'h0);
    collect(-1, 0, 1'b0);
    chk("restart_zone0", 32'(got[0]), 32'd3);
    chk("restart_zone2", 32'(got[2]), 32'd7);
    chk("restart_zone100", 32'(got[100]), 32'hFFFF);

`ifdef ZONE_FILTER_DIAG_EN
    // Diagonal neighbour reaches the corner zone.
    fill(16'd50);
    put(25, 16'd10);
    start_pass(2'b00, 1'b0, 0, 16'h0);
    collect(-1, 0, 1'b0);
    chk("diag_zone0", 32'(got[0]), 32'd30);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
